// File: rtl/vga_map_fetcher_pkg.sv
// Shared definitions for the VGA map fetcher: FSM encoding, default
// screen geometry in tiles, and the widths of the tile coordinates.
package vga_map_fetcher_pkg;

  localparam int TILES_X_DEF = 40;
  localparam int TILES_Y_DEF = 30;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;
  localparam int COL_W  = 6;
  localparam int ROW_W  = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    OUT  = 2'd2
  } state_e;

endpackage

// File: rtl/vga_map_fetcher_if.sv
// Memory read port and tile delivery port of the map fetcher.
// master = fetcher side, slave = memory/renderer side.
interface vga_map_fetcher_if;
  import vga_map_fetcher_pkg::*;

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              tile_valid;
  logic [DATA_W-1:0] tile_data;
  logic [COL_W-1:0]  tile_col;
  logic [ROW_W-1:0]  tile_row;
  logic              tile_ready;

  modport master (
    output mem_req, mem_addr, tile_valid, tile_data, tile_col, tile_row,
    input  mem_ack, mem_rdata, tile_ready
  );

  modport slave (
    input  mem_req, mem_addr, tile_valid, tile_data, tile_col, tile_row,
    output mem_ack, mem_rdata, tile_ready
  );

endinterface

// File: rtl/vga_map_addr_step.sv
// Address walker for the visible map window. Holds the current tile
// address, the base of the current map row, the row stride and the
// column/row counters; steps them to the next tile on advance_i.
module vga_map_addr_step
  import vga_map_fetcher_pkg::*;
#(
  parameter int TILES_X = TILES_X_DEF,
  parameter int TILES_Y = TILES_Y_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [ADDR_W-1:0] start_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic              advance_i,
  output logic [ADDR_W-1:0] cur_addr_o,
  output logic [COL_W-1:0]  col_o,
  output logic [ROW_W-1:0]  row_o,
  output logic              last_tile_o
);

  logic [ADDR_W-1:0] row_base_q, row_base_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [ADDR_W-1:0] stride_q,   stride_d;
  logic [COL_W-1:0]  col_q,      col_d;
  logic [ROW_W-1:0]  row_q,      row_d;
  logic              last_col;
  logic              last_row;
  logic [ADDR_W-1:0] next_row_base;

  // Next-tile computation: +1 word along a row, +stride from the row base
  // at the end of a row; sums wrap modulo 2^16.
  always_comb begin
    // NOTE: every _d gets its hold value first so no path leaves it unassigned (no latch).
    row_base_d    = row_base_q;
    cur_addr_d    = cur_addr_q;
    stride_d      = stride_q;
    col_d         = col_q;
    row_d         = row_q;
    last_col      = (col_q == COL_W'(TILES_X - 1));
    last_row      = (row_q == ROW_W'(TILES_Y - 1));
    next_row_base = row_base_q + stride_q;

    if (load_i) begin
      row_base_d = start_addr_i;
      cur_addr_d = start_addr_i;
      stride_d   = stride_i;
      col_d      = '0;
      row_d      = '0;
    end else if (advance_i && !(last_col && last_row)) begin
      if (last_col) begin
        row_base_d = next_row_base;
        cur_addr_d = next_row_base;
        col_d      = '0;
        row_d      = row_q + ROW_W'(1);
      end else begin
        cur_addr_d = cur_addr_q + ADDR_W'(1);
        col_d      = col_q + COL_W'(1);
      end
    end
  end

  // Walker state registers, cleared by the synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      row_base_q <= '0;
      cur_addr_q <= '0;
      stride_q   <= '0;
      col_q      <= '0;
      row_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      cur_addr_q <= cur_addr_d;
      stride_q   <= stride_d;
      col_q      <= col_d;
      row_q      <= row_d;
    end
  end

  assign cur_addr_o  = cur_addr_q;
  assign col_o       = col_q;
  assign row_o       = row_q;
  assign last_tile_o = last_col && last_row;

endmodule

// File: rtl/vga_map_fetcher.sv
// VGA map fetcher: once per frame walks the visible TILES_X x TILES_Y
// window of the level map, reading one word per tile and handing each
// word to the renderer in raster order. All outputs are registered.
module vga_map_fetcher
  import vga_map_fetcher_pkg::*;
#(
  parameter int TILES_X = TILES_X_DEF,
  parameter int TILES_Y = TILES_Y_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] display_start,
  input  logic [ADDR_W-1:0] row_length,
  output logic              busy,
  output logic              frame_done,
  vga_map_fetcher_if.master bus
);

  state_e            state_q;
  logic              mem_req_q;
  logic              tile_valid_q;
  logic [DATA_W-1:0] tile_data_q;
  logic              busy_q;
  logic              frame_done_q;

  logic              load;
  logic              advance;
  logic [ADDR_W-1:0] cur_addr;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic              last_tile;

  // start only counts in IDLE; tile_ready only counts in OUT.
  assign load    = (state_q == IDLE) && start;
  assign advance = (state_q == OUT) && bus.tile_ready;

  vga_map_addr_step #(
    .TILES_X (TILES_X),
    .TILES_Y (TILES_Y)
  ) u_addr_step (
    .clk          (clk),
    .reset        (reset),
    .load_i       (load),
    .start_addr_i (display_start),
    .stride_i     (row_length),
    .advance_i    (advance),
    .cur_addr_o   (cur_addr),
    .col_o        (col),
    .row_o        (row),
    .last_tile_o  (last_tile)
  );

  // Frame FSM with registered handshake outputs; frame_done is a one-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      tile_valid_q <= 1'b0;
      tile_data_q  <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q   <= REQ;
            mem_req_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        REQ: begin
          if (bus.mem_ack) begin
            state_q      <= OUT;
            mem_req_q    <= 1'b0;
            tile_valid_q <= 1'b1;
            tile_data_q  <= bus.mem_rdata;
          end
        end
        OUT: begin
          if (bus.tile_ready) begin
            tile_valid_q <= 1'b0;
            if (last_tile) begin
              state_q      <= IDLE;
              busy_q       <= 1'b0;
              frame_done_q <= 1'b1;
            end else begin
              state_q   <= REQ;
              mem_req_q <= 1'b1;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          mem_req_q    <= 1'b0;
          tile_valid_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mem_req    = mem_req_q;
  assign bus.mem_addr   = cur_addr;
  assign bus.tile_valid = tile_valid_q;
  assign bus.tile_data  = tile_data_q;
  assign bus.tile_col   = col;
  assign bus.tile_row   = row;
  assign busy           = busy_q;
  assign frame_done     = frame_done_q;

endmodule
